// File: rtl/ram_pkg.sv
// Shared definitions for the parametrised synchronous RAM.
// Contents:
//   ram_state_e - sequencer state (clear sweep vs. normal access)
//   depth()     - number of words addressed by an address of the given width
package ram_pkg;

  typedef enum logic [0:0] {
    StClear,
    StIdle
  } ram_state_e;

  function automatic int unsigned depth(input int unsigned addr_w);
    return 32'd1 << addr_w;
  endfunction

endpackage

// File: rtl/ram_core.sv
// Plain single-port storage array: one write port and one registered read port.
// A read and a write to the same address on the same edge return the old word.
// Ports:
//   clk   - clock, rising edge
//   we    - write enable
//   waddr - write address
//   wdata - write data
//   raddr - read address, sampled every edge
//   rdata - registered read data
module ram_core #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned ADDR_W = 3
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);
  import ram_pkg::*;

  localparam int unsigned Depth = depth(ADDR_W);

  logic [WIDTH-1:0] mem [Depth];

  // Non-blocking update gives read-before-write on an address collision.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/ram_sync_param.sv
// Parametrised synchronous single-port RAM with registered read, a valid strobe,
// a held output value and a hardware clear sweep after reset or on request.
// Ports:
//   clk   - clock, rising edge
//   rst   - synchronous active-high reset; starts a clear sweep
//   e     - chip enable; gates w and r
//   w     - write request
//   r     - read request
//   clr   - start a clear sweep (single-cycle pulse)
//   addr  - word address
//   DIn   - write data
//   DOut  - read data, holds between reads
//   valid - DOut was updated by a read on the last edge
//   busy  - clear sweep in progress; requests are ignored
module ram_sync_param #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              e,
  input  logic              w,
  input  logic              r,
  input  logic              clr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]  DIn,
  output logic [WIDTH-1:0]  DOut,
  output logic              valid,
  output logic              busy
);
  import ram_pkg::*;

  localparam int unsigned       Depth   = depth(ADDR_W);
  localparam logic [ADDR_W-1:0] PtrLast = ADDR_W'(Depth - 1);

  ram_state_e        state_q;
  logic [ADDR_W-1:0] ptr_q;
  logic              valid_q;
  logic [WIDTH-1:0]  hold_q;

  logic              sweep;
  logic              user_ok;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [WIDTH-1:0]  wdata;
  logic [WIDTH-1:0]  rdata;

  // Write-port mux: the sweep owns the port while clearing; user writes are
  // dropped under reset or a simultaneous clr.
  always_comb begin
    sweep   = (state_q == StClear);
    user_ok = (state_q == StIdle) & ~clr;
    we      = ~rst & (sweep | (user_ok & e & w));
    waddr   = sweep ? ptr_q : addr;
    wdata   = sweep ? '0 : DIn;
  end

  ram_core #(
    .WIDTH  (WIDTH),
    .ADDR_W (ADDR_W)
  ) u_core (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .raddr (addr),
    .rdata (rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StClear;
      ptr_q   <= '0;
      valid_q <= 1'b0;
      hold_q  <= '0;
    end else begin
      // Capture the last read word so DOut keeps it once valid drops.
      if (valid_q) begin
        hold_q <= rdata;
      end
      unique case (state_q)
        StClear: begin
          valid_q <= 1'b0;
          ptr_q   <= ptr_q + 1'b1;
          if (ptr_q == PtrLast) begin
            state_q <= StIdle;
          end
        end
        StIdle: begin
          if (clr) begin
            state_q <= StClear;
            ptr_q   <= '0;
            valid_q <= 1'b0;
          end else begin
            valid_q <= e & r;
          end
        end
      endcase
    end
  end

  // rdata is only fresh on the cycle after a read; otherwise show the held word.
  assign DOut  = valid_q ? rdata : hold_q;
  assign valid = valid_q;
  assign busy  = (state_q == StClear);

endmodule

// File: tb/tb_ram_sync_param.sv
module tb_ram_sync_param;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        e = 1'b0;
  logic        w = 1'b0;
  logic        r = 1'b0;
  logic        clr = 1'b0;
  logic [2:0]  addr = '0;
  logic [15:0] DIn = '0;
  logic [15:0] DOut;
  logic        valid;
  logic        busy;

  ram_sync_param #(
    .WIDTH  (16),
    .ADDR_W (3)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .e     (e),
    .w     (w),
    .r     (r),
    .clr   (clr),
    .addr  (addr),
    .DIn   (DIn),
    .DOut  (DOut),
    .valid (valid),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Reference model state
  logic [15:0] mem_m [8];
  logic        clr_m   = 1'b0;
  int          ptr_m   = 0;
  logic        valid_m = 1'b0;
  logic [15:0] dout_m  = '0;
  logic [15:0] sb_q [$];
  int          busy_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive one cycle of stimulus, advance the model, then check after the edge.
  task automatic cyc(input logic i_rst, input logic i_e, input logic i_w, input logic i_r,
                     input logic i_clr, input logic [2:0] i_addr, input logic [15:0] i_din);
    logic [15:0] exp;
    rst = i_rst; e = i_e; w = i_w; r = i_r; clr = i_clr; addr = i_addr; DIn = i_din;
    if (i_rst) begin
      clr_m = 1'b1; ptr_m = 0; valid_m = 1'b0; dout_m = '0;
      sb_q.delete();
    end else if (clr_m) begin
      mem_m[ptr_m] = '0;
      if (ptr_m == 7) clr_m = 1'b0;
      ptr_m++;
      valid_m = 1'b0;
    end else if (i_clr) begin
      clr_m = 1'b1; ptr_m = 0; valid_m = 1'b0;
    end else begin
      valid_m = i_e & i_r;
      if (valid_m) begin
        dout_m = mem_m[i_addr];
        sb_q.push_back(dout_m);
      end
      if (i_e & i_w) mem_m[i_addr] = i_din;
    end
    @(posedge clk);
    #1;
    check("busy", 32'(busy), 32'(clr_m));
    check("valid", 32'(valid), 32'(valid_m));
    check("dout", 32'(DOut), 32'(dout_m));
    if (valid) begin
      check("sb_depth", sb_q.size(), 1);
      if (sb_q.size() > 0) begin
        exp = sb_q.pop_front();
        check("sb_data", 32'(DOut), 32'(exp));
      end
    end
    if (busy) busy_cnt++;
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0);
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, a, d);
  endtask

  task automatic rd(input logic [2:0] a);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, a, 16'h0);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) mem_m[i] = '0;
    @(posedge clk);
    #1;

    // 1: reset sweep, then every word reads zero
    busy_cnt = 0;
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0);
    check("s1_rst_dout", 32'(DOut), 32'h0);
    for (int i = 0; i < 8; i++) idle();
    check("s1_busy_edges", busy_cnt, 8);
    for (int i = 0; i < 8; i++) begin
      rd(3'(i));
      check("s1_zero", 32'(DOut), 32'h0);
    end

    // 2: write then read back, then hold
    wr(3'd3, 16'hBEEF);
    rd(3'd3);
    check("s2_rd", 32'(DOut), 32'hBEEF);
    check("s2_valid", 32'(valid), 32'h1);
    idle();
    check("s2_hold", 32'(DOut), 32'hBEEF);
    check("s2_nvalid", 32'(valid), 32'h0);

    // 3: read-before-write collision
    wr(3'd5, 16'h1234);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 3'd5, 16'hAAAA);
    check("s3_old", 32'(DOut), 32'h1234);
    rd(3'd5);
    check("s3_new", 32'(DOut), 32'hAAAA);

    // 4: clr beats a simultaneous write; reads during the sweep are ignored
    for (int i = 0; i < 8; i++) wr(3'(i), 16'(16'h1001 + i));
    rd(3'd7);
    busy_cnt = 0;
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 3'd0, 16'hFFFF);
    for (int i = 0; i < 8; i++) rd(3'(i));
    check("s4_busy_edges", busy_cnt, 8);
    check("s4_hold", 32'(DOut), 32'h1008);
    for (int i = 0; i < 8; i++) begin
      rd(3'(i));
      check("s4_zero", 32'(DOut), 32'h0);
    end

    // 5: reset mid-sweep restarts the full sweep
    wr(3'd1, 16'h0077);
    rd(3'd1);
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 3'd1, 16'h0);
    for (int i = 0; i < 3; i++) rd(3'd1);
    busy_cnt = 0;
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0);
    for (int i = 0; i < 8; i++) rd(3'd1);
    check("s5_busy_edges", busy_cnt, 8);
    check("s5_dout", 32'(DOut), 32'h0);
    rd(3'd1);
    check("s5_cleared", 32'(DOut), 32'h0);
    check("s5_valid", 32'(valid), 32'h1);

    // 6: disabled write leaves memory alone
    wr(3'd2, 16'h0F0F);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd2, 16'h5555);
    rd(3'd2);
    check("s6_old", 32'(DOut), 32'h0F0F);

    // Random traffic with occasional clear requests
    for (int i = 0; i < 80; i++) begin
      cyc(1'b0, 1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom),
          1'($urandom_range(0, 31) == 0), 3'($urandom), 16'($urandom));
    end
    for (int i = 0; i < 10; i++) idle();
    check("sb_drain", sb_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
